risc_loader: RTL and testbench
==============================

# risc_loader

Program loader for the RISC core: accepts a byte stream over a valid/ready handshake, writes it into the shared program/data memory through the memory write port, verifies a checksum, then releases the core from reset. It is the writer for the memory image that the core fetches and reads. The top level muxes the memory address, data and write lines to the loader whenever `cpu_rst` is high.

## Interface
- `AWIDTH`, 5, memory address width; memory depth is 2^AWIDTH words.
- `DWIDTH`, 8, memory data width and stream byte width.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; honoured in IDLE, RUN, ERROR.
- `in_valid`  in  1  stream byte present on `in_data`.
- `in_data`  in  DWIDTH  stream byte.
- `in_ready`  out  1  loader can accept a byte.
- `mem_wr`  out  1  memory write strobe, one cycle per word.
- `mem_addr`  out  AWIDTH  write address.
- `mem_wdata`  out  DWIDTH  write data.
- `cpu_rst`  out  1  holds the core in reset; the core's `rst` is ORed with this signal.
- `done`  out  1  load verified, core running.
- `err`  out  1  load failed; the core stays in reset.

## Operation
- Stream format: LEN byte (N), then N data bytes to addresses 0..N-1, then a CHECKSUM byte equal to the sum of the data bytes mod 2^DWIDTH.
- Beat accepted on a rising edge with `in_valid && in_ready`. `in_ready` is decoded from the state: 1 in LEN, DATA and CSUM, 0 elsewhere.
- IDLE: `cpu_rst`=1. `start` → LEN. Entry into LEN clears the index, sum, `done` and `err`.
- LEN: accepted N with 1 ≤ N ≤ 2^AWIDTH → DATA, count=N. N=0 or N>2^AWIDTH → ERROR.
- DATA: each accepted byte is registered into `mem_wdata`, `mem_addr`=index. `mem_wr` pulses, index increments, sum += byte (DWIDTH-bit, wrapping). After the Nth byte → CSUM.
- CSUM: accepted byte == sum → RUN. Otherwise → ERROR.
- RUN: `cpu_rst`=0, `done`=1. `start` → LEN; `cpu_rst` reasserts in the cycle LEN is entered.
- ERROR: `cpu_rst`=1, `err`=1. `start` → LEN.
- `start` is ignored in LEN, DATA and CSUM.
- The index register is AWIDTH+1 bits wide; `mem_addr` is its low AWIDTH bits and never wraps within a load.

## Timing
- Reset values: state IDLE, `cpu_rst`=1, `in_ready`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `err`=0, index=0, sum=0.
- `mem_wr`, `mem_addr` and `mem_wdata` are registered. The write strobe appears in the cycle after acceptance and lasts exactly one cycle. `mem_addr` and `mem_wdata` hold their values until the next write.
- Back-to-back accepts produce back-to-back writes. The last data write coincides with the first CSUM cycle.
- Minimum load time is N+2 accepted beats. `done` or `err` rises one cycle after the CSUM or failing LEN beat; `cpu_rst` falls in the same cycle as `done` rises.
- Stalls: idle `in_valid` cycles insert no writes and change no state.
- `rst` mid-load: next cycle is IDLE with reset values. Any pending write is dropped (`mem_wr`=0). Memory contents already written are left as they are.
- `rst` and `start` in the same cycle: `rst` wins.

## Test plan
- Reset: assert `rst` 2 cycles → `cpu_rst`=1, `in_ready`=0, `mem_wr`=0, `done`=0, `err`=0. Idle for 5 cycles with no `start` → all outputs unchanged.
- Basic load: `start`, then stream 03,A0,21,FF,C0 back-to-back → writes (0,A0), (1,21), (2,FF) on consecutive cycles. One cycle after C0 is accepted: `done`=1, `cpu_rst`=0.
- Full depth: LEN=20h, data 00..1F, CHECKSUM F0 with random `in_valid` gaps → 32 writes, last to address 1F, `done`=1, no write while `in_valid`=0.
- Bad checksum: 02,10,20, CHECKSUM 31 → `err`=1, `cpu_rst`=1, `done`=0. Then `start` plus a valid stream → `err` clears and `done`=1.
- Illegal length: LEN=00, and separately LEN=21h → ERROR one cycle later with zero `mem_wr` pulses. `in_ready`=0 afterwards.
- Mid-load reset: `rst` after the 2nd of 4 data bytes → IDLE next cycle, no further `mem_wr`. `start` during DATA (without `rst`) is ignored.

Source files
------------

// File: rtl/risc_loader.sv
// Program loader: receives LEN / data / CHECKSUM over valid/ready, writes the
// image into program memory, then releases the core from reset if the checksum matches.
module risc_loader #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  localparam int unsigned DEPTH = 2 ** AWIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CSUM  = 3'd3,
    S_RUN   = 3'd4,
    S_ERROR = 3'd5
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [AWIDTH:0]   idx;
  logic [AWIDTH:0]   count;
  logic [AWIDTH:0]   idx_inc;
  logic [DWIDTH-1:0] sum;
  logic              accept;
  logic              len_ok;

  assign accept  = in_valid && in_ready;
  assign idx_inc = idx + {{AWIDTH{1'b0}}, 1'b1};
  assign len_ok  = (in_data != {DWIDTH{1'b0}}) && (32'(in_data) <= DEPTH);

  // Next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN;
        else       state_next = S_IDLE;
      end
      S_LEN: begin
        if (accept) state_next = len_ok ? S_DATA : S_ERROR;
        else        state_next = S_LEN;
      end
      S_DATA: begin
        if (accept && (idx_inc == count)) state_next = S_CSUM;
        else                              state_next = S_DATA;
      end
      S_CSUM: begin
        if (accept) state_next = (in_data == sum) ? S_RUN : S_ERROR;
        else        state_next = S_CSUM;
      end
      S_RUN, S_ERROR: begin
        if (start) state_next = S_LEN;
        else       state_next = state;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, status outputs and memory write port; status flags follow the next state
  // so they change in the same cycle the state does.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b0;
      cpu_rst   <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= {AWIDTH{1'b0}};
      mem_wdata <= {DWIDTH{1'b0}};
      idx       <= {(AWIDTH+1){1'b0}};
      count     <= {(AWIDTH+1){1'b0}};
      sum       <= {DWIDTH{1'b0}};
    end else begin
      state    <= state_next;
      in_ready <= (state_next == S_LEN) || (state_next == S_DATA) || (state_next == S_CSUM);
      cpu_rst  <= (state_next != S_RUN);
      done     <= (state_next == S_RUN);
      err      <= (state_next == S_ERROR);
      mem_wr   <= 1'b0;
      if ((state_next == S_LEN) && (state != S_LEN)) begin
        idx <= {(AWIDTH+1){1'b0}};
        sum <= {DWIDTH{1'b0}};
      end
      case (state)
        S_LEN: begin
          if (accept) count <= (AWIDTH+1)'(in_data);
        end
        S_DATA: begin
          if (accept) begin
            mem_wr    <= 1'b1;
            mem_addr  <= idx[AWIDTH-1:0];
            mem_wdata <= in_data;
            idx       <= idx_inc;
            sum       <= sum + in_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_risc_loader.sv
// Scoreboard bench for risc_loader: stimulus pushes expected memory writes (with the
// cycle they must appear in); a negedge monitor pops and compares every mem_wr pulse.
module tb_risc_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_rst;
  logic       done;
  logic       err;

  always #5 clk = ~clk;

  risc_loader #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [7:0]  d;
    logic [31:0] c;
  } wr_t;

  wr_t         exp_q[$];
  int          passes = 0;
  int          total  = 0;
  int unsigned cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (mem_wr !== 1'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {27'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", {27'd0, mem_addr}, {27'd0, e.a});
        chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
        chk("wr_cycle", cyc, e.c);
      end
    end
  end

  // All tasks are entered and left at a negedge.
  task automatic send(input logic [7:0] b, input bit is_data, input logic [4:0] addr,
                      input int gap_max);
    int g;
    bit acc;
    g   = (gap_max > 0) ? $urandom_range(gap_max, 0) : 0;
    acc = 1'b0;
    in_valid = 1'b0;
    repeat (g) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    for (int t = 0; t < 100; t++) begin
      if (in_ready === 1'b1) begin
        acc = 1'b1;
        if (is_data) exp_q.push_back('{a: addr, d: b, c: cyc + 1});
      end
      @(negedge clk);
      if (acc) break;
    end
    in_valid = 1'b0;
    chk("accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    chk("len_in_ready", {31'd0, in_ready}, 32'd1);
    chk("len_done_clr", {31'd0, done}, 32'd0);
    chk("len_err_clr", {31'd0, err}, 32'd0);
  endtask

  // Reference model: LEN must be 1..32, data goes to 0..N-1, checksum is the byte sum.
  task automatic run_load(input logic [7:0] s[$], input int gap_max);
    int         n;
    bit         ok;
    logic [7:0] total_sum;
    n         = int'(s[0]);
    total_sum = 8'd0;
    do_start();
    send(s[0], 1'b0, 5'd0, gap_max);
    if (n >= 1 && n <= 32) begin
      for (int i = 0; i < n; i++) begin
        send(s[1+i], 1'b1, 5'(i), gap_max);
        total_sum = total_sum + s[1+i];
      end
      send(s[n+1], 1'b0, 5'd0, gap_max);
      ok = (s[n+1] == total_sum);
    end else begin
      ok = 1'b0;
    end
    chk("end_done", {31'd0, done}, {31'd0, ok});
    chk("end_err", {31'd0, err}, {31'd0, !ok});
    chk("end_cpu_rst", {31'd0, cpu_rst}, {31'd0, !ok});
    chk("end_in_ready", {31'd0, in_ready}, 32'd0);
    chk("writes_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_addr"}, {27'd0, mem_addr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, mem_wdata}, 32'd0);
  endtask

  initial begin
    logic [7:0] s[$];
    logic [7:0] d;
    logic [7:0] acc_sum;
    int         n;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_idle("idle");
    end

    // Basic back-to-back load.
    s = '{8'h03, 8'hA0, 8'h21, 8'hFF, 8'hC0};
    run_load(s, 0);

    // Full depth with random gaps.
    s = '{};
    s.push_back(8'h20);
    for (int i = 0; i < 32; i++) s.push_back(8'(i));
    s.push_back(8'hF0);
    run_load(s, 3);

    // Bad checksum, then recovery.
    s = '{8'h02, 8'h10, 8'h20, 8'h31};
    run_load(s, 1);
    s = '{8'h02, 8'h10, 8'h20, 8'h30};
    run_load(s, 1);

    // Illegal lengths.
    s = '{8'h00};
    run_load(s, 0);
    s = '{8'h21};
    run_load(s, 2);

    // Randomized loads, some with a corrupted checksum or illegal length.
    for (int k = 0; k < 8; k++) begin
      s = '{};
      if (k == 5) begin
        s.push_back(8'($urandom_range(255, 33)));
      end else begin
        n = $urandom_range(32, 1);
        acc_sum = 8'd0;
        s.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
          d = 8'($urandom);
          s.push_back(d);
          acc_sum = acc_sum + d;
        end
        if ($urandom_range(3, 0) == 0) acc_sum = acc_sum + 8'd1;
        s.push_back(acc_sum);
      end
      run_load(s, $urandom_range(2, 0));
    end

    // rst and start together: rst wins.
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check_idle("rst_start");
    @(negedge clk);
    chk("rst_start_stay", {31'd0, in_ready}, 32'd0);

    // Mid-load reset, with an ignored start during DATA.
    do_start();
    send(8'h04, 1'b0, 5'd0, 0);
    send(8'h11, 1'b1, 5'd0, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_in_data_ignored", {31'd0, in_ready}, 32'd1);
    send(8'h22, 1'b1, 5'd1, 0);
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h33;
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst");
    repeat (4) begin
      in_data = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("midrst_no_writes", exp_q.size(), 32'd0);
    check_idle("midrst_after");

    s = '{8'h01, 8'h5A, 8'h5A};
    run_load(s, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
